// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, legal oversampling ratios, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // Parity bit to transmit / expect; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-point majority sampler; bit_done_o marks the last
// oversampling edge of a bit, sample_o is the voted value valid from mid-bit onward.
module uart_rx_sampler (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  input  logic       rx_i,
  input  logic [5:0] prescale_i,
  output logic       bit_done_o,
  output logic       sample_o
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [5:0] half;
  logic [2:0] smp_q, smp_d;

  always_comb begin
    half       = prescale_i >> 1;
    bit_done_o = run_i && (edge_cnt_q == prescale_i - 6'd1);
    edge_cnt_d = edge_cnt_q + 6'd1;
    if (!run_i || bit_done_o) edge_cnt_d = '0;
    smp_d = smp_q;
    if (run_i && (edge_cnt_q == half - 6'd1)) smp_d[0] = rx_i;
    if (run_i && (edge_cnt_q == half))        smp_d[1] = rx_i;
    if (run_i && (edge_cnt_q == half + 6'd1)) smp_d[2] = rx_i;
  end

  assign sample_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start detection, LSB-first deserializer, parity and stop checks.
// Status pulses are registered at the stop-bit boundary and last one cycle; the line cannot be stalled.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);
  import uart_pkg::*;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  rx_state_e             state_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  par_flag_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            prescale_q;
  logic                  dv_q, pe_q, se_q;
  logic                  run, bit_done, sample;

  assign run = (state_q != IDLE);

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run),
    .rx_i       (RX_IN),
    .prescale_i (prescale_q),
    .bit_done_o (bit_done),
    .sample_o   (sample)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      p_data_q   <= '0;
      par_flag_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!RX_IN) begin
            state_q    <= START;
            bit_cnt_q  <= '0;
            par_flag_q <= 1'b0;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            prescale_q <= Prescale;
          end
        end
        START: begin
          // An unsupported ratio would mistime every sample, so drop the frame at once.
          if (!prescale_legal(prescale_q)) state_q <= IDLE;
          else if (bit_done)               state_q <= sample ? IDLE : DATA;
        end
        DATA: begin
          if (bit_done) begin
            data_q[bit_cnt_q] <= sample;
            if (bit_cnt_q == LAST_BIT) state_q <= par_en_q ? PARITY : STOP;
            else                       bit_cnt_q <= bit_cnt_q + BIT_ONE;
          end
        end
        PARITY: begin
          if (bit_done) begin
            par_flag_q <= (sample != parity_bit(32'(data_q), par_typ_q));
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            dv_q <= !par_flag_q && sample;
            pe_q <= par_flag_q;
            se_q <= !sample;
            if (!par_flag_q && sample) p_data_q <= data_q;
            // A low line right at the boundary is the next start bit.
            if (!RX_IN) begin
              state_q    <= START;
              bit_cnt_q  <= '0;
              par_flag_q <= 1'b0;
              par_en_q   <= PAR_EN;
              par_typ_q  <= PAR_TYP;
              prescale_q <= Prescale;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a frame-level expectation model checked every cycle.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stp_Err;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_pdata = 8'h00;
  int checks = 0;
  int errors = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, last_dv_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Per-cycle comparison against the frame-level expectations.
  initial begin
    logic e_dv, e_pe, e_se;
    forever begin
      @(negedge clk);
      e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0;
      if (!reset) begin
        exp_q.delete();
        exp_pdata = 8'h00;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e_dv = exp_q[0].dv;
        e_pe = exp_q[0].pe;
        e_se = exp_q[0].se;
        if (exp_q[0].dv) exp_pdata = exp_q[0].d;
        void'(exp_q.pop_front());
      end
      chk("Data_Valid", 32'(Data_Valid), 32'(e_dv));
      chk("Par_Err",    32'(Par_Err),    32'(e_pe));
      chk("Stp_Err",    32'(Stp_Err),    32'(e_se));
      chk("P_DATA",     32'(P_DATA),     32'(exp_pdata));
      if (Data_Valid === 1'b1) begin n_dv++; last_dv_cyc = cyc; end
      if (Par_Err === 1'b1) n_pe++;
      if (Stp_Err === 1'b1) n_se++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) tick();
  endtask

  // Sends one frame; the DUT first sees the start bit one edge after 'start',
  // and the status pulse appears at the end of the final bit.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp, input bit pbit,
                            input bit stop, input int p, input bit scramble, output int start);
    ev_t ev;
    int  nb;
    bit  perr;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    Prescale = 6'(p);
    nb   = pen ? 11 : 10;
    perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
    start = cyc;
    if (p == 8 || p == 16 || p == 32) begin
      ev.cyc = start + 1 + nb * p;
      ev.dv  = !perr && stop;
      ev.pe  = perr;
      ev.se  = !stop;
      ev.d   = d;
      exp_q.push_back(ev);
    end
    drive_bit(1'b0, p);
    if (scramble) begin
      Prescale = 6'd8;
      PAR_EN   = !pen;
      PAR_TYP  = !ptyp;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stop, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    int s, s2, dv0, pe0, se0;
    ev_t ev;
    repeat (4) tick();
    chk("reset_pdata", 32'(P_DATA), 32'h0);
    chk("reset_dv", 32'(Data_Valid), 32'h0);
    reset = 1'b1;
    repeat (4) tick();

    // 0xA5 at x8, no parity
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'hA5, 0, 0, 0, 1, 8, 0, s);
    repeat (12) tick();
    chk("a5_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("a5_err_count", 32'(n_pe - pe0 + n_se - se0), 32'd0);
    chk("a5_pdata", 32'(P_DATA), 32'hA5);
    // start seen at s+1, Data_Valid registered 80 clocks later
    chk("a5_latency", 32'(last_dv_cyc - s), 32'd81);

    // 0x3C at x16 even parity, wrong parity bit 1; config scrambled mid-frame
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h3C, 1, 0, 1, 1, 16, 1, s);
    repeat (20) tick();
    chk("3c_pe_count", 32'(n_pe - pe0), 32'd1);
    chk("3c_dv_count", 32'(n_dv - dv0), 32'd0);
    chk("3c_se_count", 32'(n_se - se0), 32'd0);
    chk("3c_pdata_hold", 32'(P_DATA), 32'hA5);

    // 0x81 at x32 with stop 0, then 0x7E good
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h81, 0, 0, 0, 0, 32, 0, s);
    repeat (40) tick();
    chk("81_se_count", 32'(n_se - se0), 32'd1);
    chk("81_dv_count", 32'(n_dv - dv0), 32'd0);
    chk("81_pe_count", 32'(n_pe - pe0), 32'd0);
    send_frame(8'h7E, 0, 0, 0, 1, 32, 0, s);
    repeat (40) tick();
    chk("7e_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("7e_pdata", 32'(P_DATA), 32'h7E);

    // 3-clock low glitch at x16, then 0x55
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    Prescale = 6'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 24);
    chk("glitch_pulses", 32'(n_dv - dv0 + n_pe - pe0 + n_se - se0), 32'd0);
    send_frame(8'h55, 0, 0, 0, 1, 16, 0, s);
    repeat (20) tick();
    chk("55_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("55_pdata", 32'(P_DATA), 32'h55);

    // back-to-back 0x01 (odd parity bit 0) and 0xFF (odd parity bit 1) at x8
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h01, 1, 1, 0, 1, 8, 0, s);
    send_frame(8'hFF, 1, 1, 1, 1, 8, 0, s2);
    repeat (12) tick();
    chk("b2b_dv_count", 32'(n_dv - dv0), 32'd2);
    chk("b2b_err_count", 32'(n_pe - pe0 + n_se - se0), 32'd0);
    chk("b2b_pdata", 32'(P_DATA), 32'hFF);

    // break: line held low for two frame times at x8
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    Prescale = 6'd8; PAR_EN = 1'b0;
    s = cyc;
    ev.dv = 1'b0; ev.pe = 1'b0; ev.se = 1'b1; ev.d = 8'h00;
    ev.cyc = s + 81;  exp_q.push_back(ev);
    ev.cyc = s + 161; exp_q.push_back(ev);
    drive_bit(1'b0, 160);
    drive_bit(1'b1, 12);
    chk("break_se_count", 32'(n_se - se0), 32'd2);
    chk("break_dv_count", 32'(n_dv - dv0), 32'd0);

    // unsupported ratio 12: frame ignored
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h0F, 0, 0, 0, 1, 12, 0, s);
    repeat (20) tick();
    chk("bad_ps_pulses", 32'(n_dv - dv0 + n_pe - pe0 + n_se - se0), 32'd0);

    // reset during data bit 4 at x16, then 0x99
    Prescale = 6'd16; PAR_EN = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    reset = 1'b0;
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    RX_IN = 1'b1;
    repeat (4) tick();
    chk("rst_dv", 32'(Data_Valid), 32'h0);
    reset = 1'b1;
    repeat (5) tick();
    dv0 = n_dv; pe0 = n_pe; se0 = n_se;
    send_frame(8'h99, 0, 0, 0, 1, 16, 0, s);
    repeat (20) tick();
    chk("99_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("99_err_count", 32'(n_pe - pe0 + n_se - se0), 32'd0);
    chk("99_pdata", 32'(P_DATA), 32'h99);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
